rmt_ctrl_pkt_gen: RTL and testbench
===================================

# rmt_ctrl_pkt_gen

Control-packet transmitter for the RMT pipeline. It builds the 512-bit AXI-Stream control packets that the RMT ingress parser recognises as table-configuration writes (UDP dst port 0xf1f2), and emits them toward `rmt_wrapper` `s_axis_*`. Each packet is one generated header beat followed by payload beats taken from a configuration-data stream. The block sits between the host/config agent and the data-path arbiter feeding the pipeline.

## Interface
Parameters:
- `C_M_AXIS_DATA_WIDTH`, 512, output data width; fixed at 512 because the header layout depends on it.
- `C_M_AXIS_TUSER_WIDTH`, 128, output tuser width; driven as all zeros.
- `CTRL_UDP_PORT`, 16'hf1f2, UDP destination-port value placed in the header.
- `MAX_PAYLOAD_BEATS`, 8, maximum payload beats per packet (1..255).
- `CNT_WIDTH`, 32, width of the statistics counters.

Ports:
- `clk`, in, 1, clock. One clock domain only.
- `aresetn`, in, 1, reset. Asynchronous, active-low.
- `req_valid`, in, 1, request to start a packet.
- `req_ready`, out, 1, request accepted when `req_valid && req_ready`.
- `req_mod_id`, in, 8, target module ID.
- `req_resv`, in, 4, reserved/stage field.
- `req_index`, in, 8, table entry index.
- `cfg_tdata`, in, 512, payload beat.
- `cfg_tvalid`, in, 1, payload valid.
- `cfg_tready`, out, 1, payload ready.
- `cfg_tlast`, in, 1, last payload beat.
- `m_axis_tdata`, out, 512, output data.
- `m_axis_tkeep`, out, 64, output byte enables.
- `m_axis_tuser`, out, 128, output tuser.
- `m_axis_tvalid`, out, 1, output valid.
- `m_axis_tready`, in, 1, output ready.
- `m_axis_tlast`, out, 1, output last beat.
- `pkt_cnt`, out, CNT_WIDTH, number of packets fully sent.
- `trunc_cnt`, out, CNT_WIDTH, number of packets truncated at the limit.

## Operation
- The state machine has four states: IDLE, HDR, PAYLOAD, DRAIN. The reset state is IDLE.
- The output register is loadable when `ld = !m_axis_tvalid || m_axis_tready`.
- **IDLE**
  - `req_ready = ld`.
  - On request accept, load the header beat into the output register, latch nothing else, clear `beat_cnt`, and go to PAYLOAD.
  - Header bits:
    - [143:128] = 16'h0008
    - [223:216] = 8'h11
    - [335:320] = `CTRL_UDP_PORT`
    - [375:368] = `req_mod_id`
    - [383:380] = `req_resv`
    - [391:384] = `req_index`
    - All other bits are 0.
  - Header beat has `tkeep` = all ones and `tlast` = 0.
- **HDR**
  - Reserved encoding; never entered.
  - If it is reached, the block returns to IDLE on the next cycle.
- **PAYLOAD**
  - `cfg_tready = ld`.
  - Each accepted beat is copied to the output with `tkeep` = all ones, and `beat_cnt` increments.
  - Output `tlast = cfg_tlast || (beat_cnt == MAX_PAYLOAD_BEATS-1)`.
  - If `cfg_tlast` is set: increment `pkt_cnt` and go to IDLE.
  - Else if the limit is hit: increment `pkt_cnt` and `trunc_cnt`, and go to DRAIN.
- **DRAIN**
  - `cfg_tready = 1`.
  - Input beats are discarded.
  - On `cfg_tvalid && cfg_tlast`, go to IDLE.
- `cfg_tready` = 0 in IDLE. `req_ready` = 0 outside IDLE.
- Counters wrap modulo 2^CNT_WIDTH.
- `m_axis_tuser` is always 0.

## Timing
- **Reset values:**
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `m_axis_tuser` = 0.
  - `req_ready` = 0, `cfg_tready` = 0.
  - `pkt_cnt` = 0, `trunc_cnt` = 0, `beat_cnt` = 0.
  - State is IDLE.
- **Reset mid-packet:** the packet is abandoned immediately. No tlast is emitted and no counter increments.
- **Latency:**
  - Header appears on `m_axis_tvalid` one cycle after request accept.
  - Each payload beat appears one cycle after its accept.
- **Throughput:** one beat per cycle. There is no gap between the header and the first payload, or between a packet's last beat and the next header.
- **Output stability:** while `m_axis_tvalid && !m_axis_tready`, `tdata`, `tkeep`, `tlast` and `tvalid` hold stable.
- **Ready signals:** `cfg_tready` and `req_ready` are combinational from state and `m_axis_tready`. There is no combinational path from `cfg_tvalid` to `cfg_tready`.
- **Counter timing:** counters update on the edge on which the tlast beat is loaded into the output register.

## Structure
- Shared package `rmt_ctrl_pkg` holds:
  - Field offsets (ETH_TYPE_LSB = 128, IP_PROTO_LSB = 216, UDP_DPORT_LSB = 320, MOD_ID_LSB = 368, RESV_LSB = 380, INDEX_LSB = 384).
  - Constants ETH_TYPE_IPV4_SWAPPED = 16'h0008 and IP_PROTO_UDP = 8'h11.
  - The state encoding.
  - These are shared with the parser-side decoder.
- One natural sub-module, `rmt_ctrl_hdr_build`: combinational header assembly from mod_id, resv and index.

## Test plan
1. **Basic packet.** Request mod_id=0, resv=0, index=0; 4 payload beats of 18'hffff, last with tlast; `m_axis_tready`=1.
   - Expect 5 consecutive output beats.
   - Beat 0 has [335:320]=f1f2, [223:216]=11, [143:128]=0008.
   - tlast only on beat 4; `pkt_cnt`=1.
2. **Header fields.** Request mod_id=8'h01, resv=4'h1, index=8'h05; 1 payload beat.
   - Expect 2 beats.
   - Header has [375:368]=01, [383:380]=1, [391:384]=05.
   - Beat 1 has tlast=1.
3. **Backpressure.** `m_axis_tready` pattern 1,0,1,0… during a 4-beat packet.
   - Expect the same 5 beats in order, no duplication or loss.
   - Data stable during stalls; `cfg_tready` low whenever the output is held.
4. **Truncation.** MAX_PAYLOAD_BEATS=8; send 10 payload beats.
   - Expect 9 output beats, with tlast on the 9th (8th payload beat).
   - 2 input beats absorbed during DRAIN; `trunc_cnt`=1, `pkt_cnt`=1.
5. **Back-to-back.** Hold `req_valid` asserted during a packet.
   - Expect the second header in the cycle immediately after the first packet's tlast beat, with no idle cycle.
6. **Reset mid-packet.** Assert `aresetn`=0 after 2 payload beats.
   - Expect all outputs at reset values and counters at 0.
   - A following request yields a clean 2-beat packet.

Source files
------------

// File: rtl/rmt_ctrl_pkg.sv
// Shared control-packet definitions used by the generator and the parser-side decoder.
package rmt_ctrl_pkg;

  // Bit offsets of header fields inside the 512-bit control beat
  localparam int unsigned ETH_TYPE_LSB  = 128;
  localparam int unsigned IP_PROTO_LSB  = 216;
  localparam int unsigned UDP_DPORT_LSB = 320;
  localparam int unsigned MOD_ID_LSB    = 368;
  localparam int unsigned RESV_LSB      = 380;
  localparam int unsigned INDEX_LSB     = 384;

  // Field widths
  localparam int unsigned ETH_TYPE_W  = 16;
  localparam int unsigned IP_PROTO_W  = 8;
  localparam int unsigned UDP_DPORT_W = 16;
  localparam int unsigned MOD_ID_W    = 8;
  localparam int unsigned RESV_W      = 4;
  localparam int unsigned INDEX_W     = 8;

  // Ethertype is stored byte-swapped in the beat
  localparam logic [ETH_TYPE_W-1:0] ETH_TYPE_IPV4_SWAPPED = 16'h0008;
  localparam logic [IP_PROTO_W-1:0] IP_PROTO_UDP          = 8'h11;

  // Generator states; ST_HDR is a reserved encoding that is never entered
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/rmt_ctrl_hdr_build.sv
// Combinational assembly of the control-packet header beat.
module rmt_ctrl_hdr_build
  import rmt_ctrl_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 512,
  parameter logic [UDP_DPORT_W-1:0] UDP_PORT = 16'hf1f2
) (
  input  logic [MOD_ID_W-1:0]   i_mod_id,
  input  logic [RESV_W-1:0]     i_resv,
  input  logic [INDEX_W-1:0]    i_index,
  output logic [DATA_WIDTH-1:0] o_hdr_c
);

  // Place fixed protocol constants and request fields; all other bits zero
  always_comb begin
    o_hdr_c                               = '0;
    o_hdr_c[ETH_TYPE_LSB  +: ETH_TYPE_W]  = ETH_TYPE_IPV4_SWAPPED;
    o_hdr_c[IP_PROTO_LSB  +: IP_PROTO_W]  = IP_PROTO_UDP;
    o_hdr_c[UDP_DPORT_LSB +: UDP_DPORT_W] = UDP_PORT;
    o_hdr_c[MOD_ID_LSB    +: MOD_ID_W]    = i_mod_id;
    o_hdr_c[RESV_LSB      +: RESV_W]      = i_resv;
    o_hdr_c[INDEX_LSB     +: INDEX_W]     = i_index;
  end

endmodule

// File: rtl/rmt_ctrl_pkt_gen.sv
// Control-packet transmitter: one generated header beat followed by config payload beats.
module rmt_ctrl_pkt_gen
  import rmt_ctrl_pkg::*;
#(
  parameter int unsigned   C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned   C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0]   CTRL_UDP_PORT        = 16'hf1f2,
  parameter int unsigned   MAX_PAYLOAD_BEATS    = 8,
  parameter int unsigned   CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [7:0]                        req_mod_id,
  input  logic [3:0]                        req_resv,
  input  logic [7:0]                        req_index,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    cfg_tdata,
  input  logic                              cfg_tvalid,
  output logic                              cfg_tready,
  input  logic                              cfg_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [CNT_WIDTH-1:0]              pkt_cnt,
  output logic [CNT_WIDTH-1:0]              trunc_cnt
);

  localparam int unsigned DW     = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = 8;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_tdata;
  logic [KEEP_W-1:0]     r_tkeep;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;
  logic [CNT_WIDTH-1:0]  r_trunc_cnt;
  logic [BEAT_W-1:0]     r_beat_cnt;

  logic [DW-1:0]         w_hdr;
  logic                  w_ld;
  logic                  w_at_limit;
  logic                  w_load;
  logic [DW-1:0]         w_data;
  logic                  w_last;
  logic                  w_pkt_inc;
  logic                  w_trunc_inc;
  logic                  w_beat_clr;
  logic                  w_beat_inc;

  rmt_ctrl_hdr_build #(
    .DATA_WIDTH (DW),
    .UDP_PORT   (CTRL_UDP_PORT)
  ) u_hdr_build (
    .i_mod_id (req_mod_id),
    .i_resv   (req_resv),
    .i_index  (req_index),
    .o_hdr_c  (w_hdr)
  );

  assign w_ld       = !r_tvalid || m_axis_tready;
  assign w_at_limit = (r_beat_cnt == BEAT_W'(MAX_PAYLOAD_BEATS - 1));

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, ready signals and output-register load controls
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    cfg_tready  = 1'b0;
    w_load      = 1'b0;
    w_data      = cfg_tdata;
    w_last      = 1'b0;
    w_pkt_inc   = 1'b0;
    w_trunc_inc = 1'b0;
    w_beat_clr  = 1'b0;
    w_beat_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so nothing is advertised while the block is held
        req_ready = w_ld && aresetn;
        if (req_valid && w_ld && aresetn) begin
          w_load      = 1'b1;
          w_data      = w_hdr;
          w_beat_clr  = 1'b1;
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        cfg_tready = w_ld;
        if (cfg_tvalid && w_ld) begin
          w_load     = 1'b1;
          w_data     = cfg_tdata;
          w_last     = cfg_tlast || w_at_limit;
          w_beat_inc = 1'b1;
          if (cfg_tlast) begin
            w_pkt_inc   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_at_limit) begin
            w_pkt_inc   = 1'b1;
            w_trunc_inc = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of an over-long payload
        cfg_tready = 1'b1;
        if (cfg_tvalid && cfg_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register: loads a new beat or empties when the downstream takes the current one
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_ld) begin
      r_tvalid <= w_load;
      if (w_load) begin
        r_tdata <= w_data;
        r_tkeep <= '1;
        r_tlast <= w_last;
      end
    end
  end

  // Payload beat counter and wrapping statistics counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_beat_clr)       r_beat_cnt <= '0;
      else if (w_beat_inc)  r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      if (w_pkt_inc)        r_pkt_cnt   <= r_pkt_cnt + CNT_WIDTH'(1);
      if (w_trunc_inc)      r_trunc_cnt <= r_trunc_cnt + CNT_WIDTH'(1);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = '0;
  assign pkt_cnt       = r_pkt_cnt;
  assign trunc_cnt     = r_trunc_cnt;

endmodule

// File: tb/tb_rmt_ctrl_pkt_gen.sv
// Directed self-checking bench for rmt_ctrl_pkt_gen.
module tb_rmt_ctrl_pkt_gen;

  logic          clk;
  logic          aresetn;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_mod_id;
  logic [3:0]    req_resv;
  logic [7:0]    req_index;
  logic [511:0]  cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic          cfg_tlast;
  logic [511:0]  m_axis_tdata;
  logic [63:0]   m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   pkt_cnt;
  logic [31:0]   trunc_cnt;

  rmt_ctrl_pkt_gen dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mod_id    (req_mod_id),
    .req_resv      (req_resv),
    .req_index     (req_index),
    .cfg_tdata     (cfg_tdata),
    .cfg_tvalid    (cfg_tvalid),
    .cfg_tready    (cfg_tready),
    .cfg_tlast     (cfg_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_cnt       (pkt_cnt),
    .trunc_cnt     (trunc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cfg_pops = 0;
  int stall_bad = 0;
  int stall_seen = 0;
  int exp_pkt = 0;
  int exp_trunc = 0;
  bit tog_mode = 1'b0;
  bit held = 1'b0;
  logic [511:0] held_d;
  logic         held_l;

  logic [511:0] cfg_d_q[$];
  logic         cfg_l_q[$];
  logic [19:0]  req_q[$];
  logic [511:0] o_d[$];
  logic [63:0]  o_k[$];
  logic         o_l[$];
  int           o_cyc[$];
  logic [511:0] e_d[$];
  logic         e_l[$];

  function automatic logic [511:0] exp_hdr(input logic [7:0] m, input logic [3:0] r, input logic [7:0] x);
    logic [511:0] h;
    h = '0;
    h[143:128] = 16'h0008;
    h[223:216] = 8'h11;
    h[335:320] = 16'hf1f2;
    h[375:368] = m;
    h[383:380] = r;
    h[391:384] = x;
    return h;
  endfunction

  function automatic logic [511:0] pay(input int p, input int i);
    logic [511:0] v;
    v = '0;
    v[17:0]    = 18'hffff;
    v[31:24]   = 8'(p);
    v[39:32]   = 8'(i);
    v[511:504] = 8'hA5;
    return v;
  endfunction

  task automatic drive();
    if (cfg_d_q.size() > 0) begin
      cfg_tvalid = 1'b1; cfg_tdata = cfg_d_q[0]; cfg_tlast = cfg_l_q[0];
    end else begin
      cfg_tvalid = 1'b0; cfg_tdata = '0; cfg_tlast = 1'b0;
    end
    if (req_q.size() > 0) begin
      req_valid = 1'b1; {req_mod_id, req_resv, req_index} = req_q[0];
    end else begin
      req_valid = 1'b0; {req_mod_id, req_resv, req_index} = 20'h0;
    end
    m_axis_tready = tog_mode ? ~m_axis_tready : 1'b1;
  endtask

  task automatic step();
    logic cf, rf;
    @(negedge clk);
    cf = cfg_tvalid && cfg_tready;
    rf = req_valid && req_ready;
    if (held && !(m_axis_tvalid === 1'b1 && m_axis_tdata === held_d && m_axis_tlast === held_l))
      stall_bad++;
    held = m_axis_tvalid && !m_axis_tready;
    if (held) begin
      stall_seen++;
      held_d = m_axis_tdata;
      held_l = m_axis_tlast;
      if (cfg_tready || req_ready) stall_bad++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      o_d.push_back(m_axis_tdata);
      o_k.push_back(m_axis_tkeep);
      o_l.push_back(m_axis_tlast);
      o_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cf) begin
      void'(cfg_d_q.pop_front());
      void'(cfg_l_q.pop_front());
      cfg_pops++;
    end
    if (rf) void'(req_q.pop_front());
    drive();
  endtask

  task automatic clr();
    o_d.delete(); o_k.delete(); o_l.delete(); o_cyc.delete();
    e_d.delete(); e_l.delete();
    held = 1'b0; stall_bad = 0; stall_seen = 0;
  endtask

  task automatic run(input int want, input int budget, input string nm);
    int n;
    n = 0;
    while ((o_d.size() < want || cfg_d_q.size() != 0 || req_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d beats, want %0d", nm, o_d.size(), want);
    end
  endtask

  task automatic check_beats(input string nm);
    vectors++;
    if (o_d.size() != e_d.size()) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d want %0d", nm, o_d.size(), e_d.size());
    end else begin
      for (int i = 0; i < e_d.size(); i++) begin
        vectors++;
        if (o_d[i] !== e_d[i] || o_k[i] !== KEEP_ALL || o_l[i] !== e_l[i]) begin
          miscompares++;
          $display("FAIL %s beat%0d: data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                   nm, i, o_d[i], o_k[i], o_l[i], e_d[i], KEEP_ALL, e_l[i]);
        end
      end
    end
    vectors++;
    if (pkt_cnt !== 32'(exp_pkt) || trunc_cnt !== 32'(exp_trunc)) begin
      miscompares++;
      $display("FAIL %s counters: pkt=%0d trunc=%0d want pkt=%0d trunc=%0d",
               nm, pkt_cnt, trunc_cnt, exp_pkt, exp_trunc);
    end
  endtask

  task automatic test_reset(input string nm);
    aresetn = 1'b0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_valid_last: valid=%b last=%b want 0 0", nm, m_axis_tvalid, m_axis_tlast);
    end
    vectors++;
    if (m_axis_tdata !== 512'h0 || m_axis_tkeep !== 64'h0 || m_axis_tuser !== 128'h0) begin
      miscompares++;
      $display("FAIL %s_data: data=%h keep=%h user=%h want 0", nm, m_axis_tdata, m_axis_tkeep, m_axis_tuser);
    end
    vectors++;
    if (req_ready !== 1'b0 || cfg_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready: req_ready=%b cfg_tready=%b want 0 0", nm, req_ready, cfg_tready);
    end
    vectors++;
    if (pkt_cnt !== 32'h0 || trunc_cnt !== 32'h0) begin
      miscompares++;
      $display("FAIL %s_cnt: pkt=%0d trunc=%0d want 0 0", nm, pkt_cnt, trunc_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    exp_pkt = 0;
    exp_trunc = 0;
  endtask

  task automatic test_basic();
    clr();
    req_q.push_back({8'h00, 4'h0, 8'h00});
    e_d.push_back(exp_hdr(8'h00, 4'h0, 8'h00)); e_l.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      cfg_d_q.push_back(pay(1, i)); cfg_l_q.push_back(i == 3);
      e_d.push_back(pay(1, i));     e_l.push_back(i == 3);
    end
    exp_pkt++;
    run(5, 200, "basic");
    check_beats("basic");
    vectors++;
    if (o_cyc.size() == 5 && o_cyc[4] - o_cyc[0] != 4) begin
      miscompares++;
      $display("FAIL basic_gapless: span=%0d cycles want 4", o_cyc[4] - o_cyc[0]);
    end
  endtask

  task automatic test_hdr_fields();
    clr();
    req_q.push_back({8'h01, 4'h1, 8'h05});
    cfg_d_q.push_back(pay(2, 0)); cfg_l_q.push_back(1'b1);
    e_d.push_back(exp_hdr(8'h01, 4'h1, 8'h05)); e_l.push_back(1'b0);
    e_d.push_back(pay(2, 0));                    e_l.push_back(1'b1);
    exp_pkt++;
    run(2, 200, "hdr");
    check_beats("hdr");
    vectors++;
    if (o_d.size() > 0 && {o_d[0][375:368], o_d[0][383:380], o_d[0][391:384]} !== 20'h01105) begin
      miscompares++;
      $display("FAIL hdr_fields: mod=%h resv=%h idx=%h want 01 1 05",
               o_d[0][375:368], o_d[0][383:380], o_d[0][391:384]);
    end
  endtask

  task automatic test_backpressure();
    clr();
    tog_mode = 1'b1;
    req_q.push_back({8'h03, 4'h0, 8'h07});
    e_d.push_back(exp_hdr(8'h03, 4'h0, 8'h07)); e_l.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      cfg_d_q.push_back(pay(3, i)); cfg_l_q.push_back(i == 3);
      e_d.push_back(pay(3, i));     e_l.push_back(i == 3);
    end
    exp_pkt++;
    run(5, 200, "bp");
    tog_mode = 1'b0;
    check_beats("bp");
    vectors++;
    if (stall_bad != 0 || stall_seen == 0) begin
      miscompares++;
      $display("FAIL bp_stall: violations=%0d stalls=%0d want 0 and >0", stall_bad, stall_seen);
    end
  endtask

  task automatic test_truncation();
    int p0;
    clr();
    p0 = cfg_pops;
    req_q.push_back({8'h0a, 4'h2, 8'h10});
    e_d.push_back(exp_hdr(8'h0a, 4'h2, 8'h10)); e_l.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin
      cfg_d_q.push_back(pay(4, i)); cfg_l_q.push_back(i == 9);
      if (i < 8) begin
        e_d.push_back(pay(4, i)); e_l.push_back(i == 7);
      end
    end
    exp_pkt++;
    exp_trunc++;
    run(9, 300, "trunc");
    check_beats("trunc");
    vectors++;
    if (cfg_pops - p0 != 10 || cfg_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_absorb: consumed=%0d cfg_tready=%b want 10 0", cfg_pops - p0, cfg_tready);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    req_q.push_back({8'h02, 4'h3, 8'h04});
    req_q.push_back({8'h05, 4'h6, 8'h07});
    e_d.push_back(exp_hdr(8'h02, 4'h3, 8'h04)); e_l.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      cfg_d_q.push_back(pay(5, i)); cfg_l_q.push_back(i == 2);
      e_d.push_back(pay(5, i));     e_l.push_back(i == 2);
    end
    e_d.push_back(exp_hdr(8'h05, 4'h6, 8'h07)); e_l.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      cfg_d_q.push_back(pay(6, i)); cfg_l_q.push_back(i == 1);
      e_d.push_back(pay(6, i));     e_l.push_back(i == 1);
    end
    exp_pkt += 2;
    run(7, 300, "b2b");
    check_beats("b2b");
    vectors++;
    if (o_cyc.size() == 7 && o_cyc[4] != o_cyc[3] + 1) begin
      miscompares++;
      $display("FAIL b2b_gap: hdr2 at cycle %0d want %0d", o_cyc[4], o_cyc[3] + 1);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    int n;
    clr();
    p0 = cfg_pops;
    n = 0;
    req_q.push_back({8'h07, 4'h0, 8'h01});
    for (int i = 0; i < 4; i++) begin
      cfg_d_q.push_back(pay(7, i)); cfg_l_q.push_back(i == 3);
    end
    while (cfg_pops - p0 < 2 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL rst_mid timeout: consumed=%0d want 2", cfg_pops - p0);
    end
    cfg_d_q.delete(); cfg_l_q.delete(); req_q.delete();
    tog_mode = 1'b0;
    drive();
    test_reset("rst_mid");
    clr();
    req_q.push_back({8'h09, 4'h8, 8'h22});
    cfg_d_q.push_back(pay(8, 0)); cfg_l_q.push_back(1'b1);
    e_d.push_back(exp_hdr(8'h09, 4'h8, 8'h22)); e_l.push_back(1'b0);
    e_d.push_back(pay(8, 0));                    e_l.push_back(1'b1);
    exp_pkt = 1;
    run(2, 200, "post_rst");
    check_beats("post_rst");
  endtask

  initial begin
    aresetn = 1'b0;
    m_axis_tready = 1'b1;
    req_valid = 1'b0; req_mod_id = '0; req_resv = '0; req_index = '0;
    cfg_tvalid = 1'b0; cfg_tdata = '0; cfg_tlast = 1'b0;
    test_reset("por");
    test_basic();
    test_hdr_fields();
    test_backpressure();
    test_truncation();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
